// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : EX/MEM and MEM/WB pipeline registers, req/ack data-memory port
//            with load formatting, store lane replication and access timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_rd,
   input  logic [2:0]  ex_funct3,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_reg_write,
   input  logic        ex_mem_to_reg,
   output logic        mem_stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] alu_result_MEM,
   output logic [4:0]  rd_MEM,
   output logic        reg_write_MEM,
   output logic        mem_read_MEM,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic [31:0] reg_write_data_WB,
   output logic        access_err
);

   localparam int                  c_WAIT_W    = $clog2(TIMEOUT);
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_WAIT_W-1:0] r_wait;

   logic        r_em_valid;
   logic [31:0] r_em_alu;
   logic [31:0] r_em_store_data;
   logic [4:0]  r_em_rd;
   logic [2:0]  r_em_funct3;
   logic        r_em_mem_read;
   logic        r_em_mem_write;
   logic        r_em_reg_write;
   logic        r_em_mem_to_reg;

   logic        r_wb_valid;
   logic [4:0]  r_wb_rd;
   logic        r_wb_reg_write;
   logic [31:0] r_wb_data;
   logic        r_err;

   logic        w_ex_legal;
   logic        w_em_bad;
   logic        w_access;
   logic        w_timeout;
   logic        w_retire;
   logic        w_abort;
   logic [31:0] w_wdata;
   logic [3:0]  w_be;
   logic [31:0] w_rshift;
   logic [31:0] w_load;

   // Misaligned halfword/word or an undefined size/sign encoding.
   function automatic logic f_bad_op(input logic [2:0] f3, input logic [1:0] a, input logic st);
      logic illegal;
      logic misal;
      illegal = (f3 == 3'b011) | (st ? f3[2] : (f3[2:1] == 2'b11));
      misal   = ((f3[1:0] == 2'b01) & a[0]) | ((f3[1:0] == 2'b10) & (a != 2'b00));
      return illegal | misal;
   endfunction

   assign w_ex_legal = ex_valid & (ex_mem_read | ex_mem_write)
                     & ~f_bad_op(ex_funct3, ex_alu_result[1:0], ex_mem_write);
   assign w_em_bad   = r_em_valid & (r_em_mem_read | r_em_mem_write)
                     & f_bad_op(r_em_funct3, r_em_alu[1:0], r_em_mem_write);
   assign w_access   = (r_state == S_ACCESS);

   // ACCESS is entered on the same edge that captures a legal memory op.
   always_comb begin
      w_state_nxt = r_state;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_ex_legal) w_state_nxt = S_ACCESS;
         end
         S_ACCESS: begin
            if (dmem_ack) begin
               w_state_nxt = w_ex_legal ? S_ACCESS : S_IDLE;
            end else if (r_wait == c_WAIT_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign mem_stall = w_access & ~dmem_ack;
   assign w_retire  = r_em_valid & (~w_access | dmem_ack | w_timeout);
   assign w_abort   = w_em_bad | w_timeout;

   always_comb begin
      w_wdata = r_em_store_data;
      w_be    = 4'b1111;
      case (r_em_funct3[1:0])
         2'b00: begin
            w_wdata = {4{r_em_store_data[7:0]}};
            w_be    = 4'b0001 << r_em_alu[1:0];
         end
         2'b01: begin
            w_wdata = {2{r_em_store_data[15:0]}};
            w_be    = 4'b0011 << r_em_alu[1:0];
         end
         default: ;
      endcase
   end

   assign dmem_req   = w_access;
   assign dmem_we    = w_access & r_em_mem_write;
   assign dmem_addr  = w_access ? {r_em_alu[31:2], 2'b00} : 32'd0;
   assign dmem_wdata = dmem_we ? w_wdata : 32'd0;
   assign dmem_be    = w_access ? w_be : 4'b0000;

   // Word loads are aligned, so the shifted word equals the raw word there.
   assign w_rshift = dmem_rdata >> {r_em_alu[1:0], 3'b000};

   always_comb begin
      w_load = w_rshift;
      case (r_em_funct3)
         3'b000:  w_load = {{24{w_rshift[7]}}, w_rshift[7:0]};
         3'b001:  w_load = {{16{w_rshift[15]}}, w_rshift[15:0]};
         3'b100:  w_load = {24'd0, w_rshift[7:0]};
         3'b101:  w_load = {16'd0, w_rshift[15:0]};
         default: w_load = w_rshift;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_wait  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wait  <= (w_access & ~dmem_ack & ~w_timeout) ? r_wait + 1'b1 : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_em_valid      <= 1'b0;
         r_em_alu        <= 32'd0;
         r_em_store_data <= 32'd0;
         r_em_rd         <= 5'd0;
         r_em_funct3     <= 3'd0;
         r_em_mem_read   <= 1'b0;
         r_em_mem_write  <= 1'b0;
         r_em_reg_write  <= 1'b0;
         r_em_mem_to_reg <= 1'b0;
      end else if (!mem_stall) begin
         r_em_valid      <= ex_valid;
         r_em_alu        <= ex_alu_result;
         r_em_store_data <= ex_store_data;
         r_em_rd         <= ex_rd;
         r_em_funct3     <= ex_funct3;
         r_em_mem_read   <= ex_mem_read;
         r_em_mem_write  <= ex_mem_write;
         r_em_reg_write  <= ex_reg_write;
         r_em_mem_to_reg <= ex_mem_to_reg;
      end else if (w_timeout) begin
         r_em_valid      <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_valid     <= 1'b0;
         r_wb_rd        <= 5'd0;
         r_wb_reg_write <= 1'b0;
         r_wb_data      <= 32'd0;
         r_err          <= 1'b0;
      end else begin
         r_wb_valid     <= w_retire;
         r_err          <= w_retire & w_abort;
         r_wb_reg_write <= w_retire & r_em_reg_write & ~r_em_mem_write & ~w_abort;
         if (w_retire) begin
            r_wb_rd   <= r_em_rd;
            r_wb_data <= r_em_mem_to_reg ? w_load : r_em_alu;
         end
      end
   end

   assign alu_result_MEM    = r_em_alu;
   assign rd_MEM            = r_em_rd;
   assign reg_write_MEM     = r_em_valid & r_em_reg_write;
   assign mem_read_MEM      = r_em_valid & r_em_mem_read;
   assign wb_valid          = r_wb_valid;
   assign wb_rd             = r_wb_rd;
   assign wb_reg_write      = r_wb_reg_write;
   assign reg_write_data_WB = r_wb_data;
   assign access_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed vector table, hand sequences and randomized run of
//            mem_stage against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
   logic [31:0] ex_alu_result, ex_store_data;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_funct3;
   logic        mem_stall, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic [31:0] alu_result_MEM, reg_write_data_WB;
   logic [4:0]  rd_MEM, wb_rd;
   logic        reg_write_MEM, mem_read_MEM, wb_valid, wb_reg_write, access_err;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
      .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .alu_result_MEM(alu_result_MEM), .rd_MEM(rd_MEM), .reg_write_MEM(reg_write_MEM),
      .mem_read_MEM(mem_read_MEM), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .wb_reg_write(wb_reg_write), .reg_write_data_WB(reg_write_data_WB), .access_err(access_err)
   );

   typedef struct {
      logic        valid;
      logic [31:0] alu;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        mr, mw, rw, m2r;
   } instr_t;

   typedef struct {
      instr_t      in;
      int          dly;
      logic [31:0] rdata;
      int          reqs, stalls;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic        rw;
      logic [31:0] data;
      logic        err;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic        rw;
      logic [31:0] data;
      logic        err;
   } ret_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wd;
      int          dly;
      logic [31:0] rdata;
   } acc_t;

   int     checks = 0, errors = 0;
   int     stall_exp = 0, stall_seen = 0;
   instr_t bubble;
   ret_t   eq[$];
   acc_t   mq[$];
   vec_t   tbl[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (spec arithmetic) ----------------
   function automatic int nbytes(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic is_bad(input logic [2:0] f3, input logic [31:0] addr, input logic st);
      if (f3 == 3'b011 || (!st && f3[2:1] == 2'b11) || (st && f3[2])) return 1'b1;
      return (int'(addr[1:0]) % nbytes(f3)) != 0;
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] addr,
                                            input logic [2:0] f3);
      int          n;
      logic [31:0] mask, v;
      n    = nbytes(f3);
      mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
      v    = (rd >> (8 * int'(addr[1:0]))) & mask;
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
      int n;
      n = nbytes(f3);
      return 4'(((1 << n) - 1) << int'(addr[1:0]));
   endfunction

   function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] d);
      case (nbytes(f3))
         1:       return {24'd0, d[7:0]} * 32'h0101_0101;
         2:       return {16'd0, d[15:0]} * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   task automatic model_accept(input instr_t i);
      ret_t r;
      acc_t m;
      r.rd = i.rd; r.rw = i.rw; r.data = i.alu; r.err = 1'b0;
      if (i.mr || i.mw) begin
         if (is_bad(i.f3, i.alu, i.mw)) begin
            r.rw = 1'b0; r.err = 1'b1;
         end else begin
            case ($urandom_range(0, 7))
               2: m.dly = 1;
               3: m.dly = 2;
               4: m.dly = 3;
               5: m.dly = TO - 1;
               6: m.dly = 99;
               default: m.dly = 0;
            endcase
            m.rdata = $urandom;
            m.addr  = i.alu & ~32'd3;
            m.we    = i.mw;
            m.be    = exp_be(i.f3, i.alu);
            m.wd    = exp_wd(i.f3, i.sd);
            mq.push_back(m);
            if (m.dly >= TO) begin
               r.rw = 1'b0; r.err = 1'b1; stall_exp += TO;
            end else begin
               stall_exp += m.dly;
               if (i.mw) r.rw = 1'b0;
               else if (i.m2r) r.data = exp_load(m.rdata, i.alu, i.f3);
            end
         end
      end
      eq.push_back(r);
   endtask

   // ---------------- stimulus helpers ----------------
   function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                                 input logic [2:0] f3, input logic mr, input logic mw, input logic rw);
      instr_t i;
      i.valid = 1'b1; i.alu = alu; i.sd = sd; i.rd = rd; i.f3 = f3;
      i.mr = mr; i.mw = mw; i.rw = rw; i.m2r = mr;
      return i;
   endfunction

   function automatic vec_t mkv(input instr_t in, input int dly, input logic [31:0] rdata,
                                input int reqs, input int stalls, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wd, input logic rw,
                                input logic [31:0] data, input logic err);
      vec_t v;
      v.in = in; v.dly = dly; v.rdata = rdata; v.reqs = reqs; v.stalls = stalls;
      v.addr = addr; v.be = be; v.wd = wd; v.rw = rw; v.data = data; v.err = err;
      return v;
   endfunction

   function automatic instr_t rnd_instr();
      instr_t i;
      int     k;
      i = bubble;
      if ($urandom_range(0, 6) == 0) return i;
      i.valid = 1'b1;
      i.alu   = $urandom;
      i.sd    = $urandom;
      i.rd    = 5'($urandom);
      if ($urandom_range(0, 1) == 1) i.alu[1:0] = 2'b00;
      k = $urandom_range(0, 2);
      i.mr  = (k == 1);
      i.mw  = (k == 2);
      i.m2r = i.mr;
      i.rw  = (k != 2) ? ($urandom_range(0, 4) != 0) : 1'b0;
      case ($urandom_range(0, 5))
         0: i.f3 = 3'b000;
         1: i.f3 = 3'b001;
         2: i.f3 = 3'b010;
         3: i.f3 = 3'b100;
         4: i.f3 = 3'b101;
         default: i.f3 = 3'($urandom);
      endcase
      if (i.mw && i.f3 == 3'b011) i.f3 = 3'b111;
      return i;
   endfunction

   task automatic drive(input instr_t i);
      ex_valid = i.valid; ex_alu_result = i.alu; ex_store_data = i.sd; ex_rd = i.rd;
      ex_funct3 = i.f3; ex_mem_read = i.mr; ex_mem_write = i.mw;
      ex_reg_write = i.rw; ex_mem_to_reg = i.m2r;
   endtask

   // ---------------- directed single-instruction vector ----------------
   task automatic run_vec(input vec_t v, input int idx);
      int          reqs = 0, stalls = 0, errs = 0;
      logic        seen = 1'b0, wrw = 1'b0, we = 1'b0;
      logic [4:0]  wrd = 5'd0;
      logic [31:0] wdat = 32'd0, a = 32'd0, wd = 32'd0;
      logic [3:0]  be = 4'd0;
      string       tag;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      drive(v.in);
      dmem_ack = 1'b0;
      @(posedge clk);
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         drive(bubble);
         if (c == 0) begin
            chk({tag, "_fwd_alu"}, alu_result_MEM, v.in.alu);
            chk({tag, "_fwd_rd_rw_mr"}, {rd_MEM, reg_write_MEM, mem_read_MEM},
                {v.in.rd, v.in.rw, v.in.mr});
         end
         dmem_ack   = dmem_req && (reqs == v.dly);
         dmem_rdata = v.rdata;
         if (dmem_req && reqs == 0) begin
            a = dmem_addr; wd = dmem_wdata; be = dmem_be; we = dmem_we;
         end
         if (dmem_req) reqs++;
         #1 stalls += int'(mem_stall);
         @(posedge clk);
         #1;
         errs += int'(access_err);
         if (wb_valid) begin
            seen = 1'b1; wrd = wb_rd; wrw = wb_reg_write; wdat = reg_write_data_WB;
         end
      end
      @(negedge clk);
      dmem_ack = 1'b0;
      @(posedge clk);
      #1 errs += int'(access_err);
      chk({tag, "_retired"}, seen, 1'b1);
      chk({tag, "_req_cycles"}, reqs, v.reqs);
      chk({tag, "_stall_cycles"}, stalls, v.stalls);
      chk({tag, "_err_pulses"}, errs, v.err);
      chk({tag, "_wb_rd"}, wrd, v.in.rd);
      chk({tag, "_wb_reg_write"}, wrw, v.rw);
      if (!v.err) chk({tag, "_wb_data"}, wdat, v.data);
      if (v.reqs > 0) begin
         chk({tag, "_addr"}, a, v.addr);
         chk({tag, "_we"}, we, v.in.mw);
         if (v.in.mw) begin
            chk({tag, "_be"}, be, v.be);
            chk({tag, "_wdata"}, wd, v.wd);
         end
      end
   endtask

   // ---------------- randomized run against the model ----------------
   task automatic run_random(input int n, input int drain);
      instr_t cur;
      logic   need = 1'b1, req_s, ack_s;
      int     rcnt = 0;
      ret_t   r;
      acc_t   m;
      cur = bubble;
      for (int c = 0; c < n + drain; c++) begin
         @(negedge clk);
         if (need) cur = (c < n) ? rnd_instr() : bubble;
         drive(cur);
         dmem_ack = 1'b0;
         if (dmem_req) begin
            chk("rnd_req_expected", mq.size() != 0, 1'b1);
            if (mq.size() != 0) begin
               m = mq[0];
               chk("rnd_addr", dmem_addr, m.addr);
               chk("rnd_we", dmem_we, m.we);
               if (m.we) chk("rnd_be_wdata", {28'd0, dmem_be} ^ dmem_wdata, {28'd0, m.be} ^ m.wd);
               dmem_ack   = (rcnt == m.dly);
               dmem_rdata = m.rdata;
            end
         end
         req_s = dmem_req;
         ack_s = dmem_ack;
         #1;
         stall_seen += int'(mem_stall);
         need = !mem_stall;
         if (need && cur.valid) model_accept(cur);
         if (req_s) begin
            if (ack_s || rcnt == TO - 1) begin
               if (mq.size() != 0) void'(mq.pop_front());
               rcnt = 0;
            end else begin
               rcnt++;
            end
         end
         @(posedge clk);
         #1;
         if (wb_valid) begin
            chk("rnd_wb_expected", eq.size() != 0, 1'b1);
            if (eq.size() != 0) begin
               r = eq.pop_front();
               chk("rnd_wb_rd", wb_rd, r.rd);
               chk("rnd_wb_reg_write", wb_reg_write, r.rw);
               chk("rnd_access_err", access_err, r.err);
               if (!r.err) chk("rnd_wb_data", reg_write_data_WB, r.data);
            end
         end
      end
      chk("rnd_retire_queue_empty", eq.size(), 0);
      chk("rnd_access_queue_empty", mq.size(), 0);
      chk("rnd_total_stall_cycles", stall_seen, stall_exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bubble = '{default: '0};
      tbl[0]  = mkv(mk(32'h1234, 0, 5, 3'b000, 0, 0, 1), 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234, 0);
      tbl[1]  = mkv(mk(32'h1003, 0, 7, 3'b000, 1, 0, 1), 3, 32'h80FF_FF00, 4, 3, 32'h1000, 0, 0, 1, 32'hFFFF_FF80, 0);
      tbl[2]  = mkv(mk(32'h1003, 0, 7, 3'b100, 1, 0, 1), 3, 32'h80FF_FF00, 4, 3, 32'h1000, 0, 0, 1, 32'h0000_0080, 0);
      tbl[3]  = mkv(mk(32'h2002, 32'hABCD_1234, 9, 3'b001, 0, 1, 1), 0, 0, 1, 0, 32'h2000, 4'b1100, 32'h1234_1234, 0, 32'h2002, 0);
      tbl[4]  = mkv(mk(32'h3001, 0, 3, 3'b010, 1, 0, 1), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tbl[5]  = mkv(mk(32'h4000, 0, 4, 3'b010, 1, 0, 1), 99, 0, 16, 16, 32'h4000, 0, 0, 0, 0, 1);
      tbl[6]  = mkv(mk(32'h5002, 0, 6, 3'b001, 1, 0, 1), 1, 32'h8001_7FFF, 2, 1, 32'h5000, 0, 0, 1, 32'hFFFF_8001, 0);
      tbl[7]  = mkv(mk(32'h5002, 0, 6, 3'b101, 1, 0, 1), 1, 32'h8001_7FFF, 2, 1, 32'h5000, 0, 0, 1, 32'h0000_8001, 0);
      tbl[8]  = mkv(mk(32'h6000, 0, 8, 3'b010, 1, 0, 1), 2, 32'hDEAD_BEEF, 3, 2, 32'h6000, 0, 0, 1, 32'hDEAD_BEEF, 0);
      tbl[9]  = mkv(mk(32'h7001, 32'h0000_00A5, 10, 3'b000, 0, 1, 0), 0, 0, 1, 0, 32'h7000, 4'b0010, 32'hA5A5_A5A5, 0, 32'h7001, 0);
      tbl[10] = mkv(mk(32'h7004, 32'h1122_3344, 11, 3'b010, 0, 1, 0), 1, 0, 2, 1, 32'h7004, 4'b1111, 32'h1122_3344, 0, 32'h7004, 0);
      tbl[11] = mkv(mk(32'h8000, 0, 12, 3'b011, 1, 0, 1), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tbl[12] = mkv(mk(32'h8000, 32'h5, 13, 3'b100, 0, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tbl[13] = mkv(mk(32'h2001, 32'h1, 14, 3'b001, 0, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tbl[14] = mkv(mk(32'h9000, 0, 15, 3'b010, 1, 0, 1), 15, 32'hCAFE_F00D, 16, 15, 32'h9000, 0, 0, 1, 32'hCAFE_F00D, 0);
      tbl[15] = mkv(mk(32'hA001, 0, 16, 3'b000, 1, 0, 1), 0, 32'h0000_7F00, 1, 0, 32'hA000, 0, 0, 1, 32'h0000_007F, 0);

      rst_n = 1'b0;
      dmem_ack = 1'b0;
      dmem_rdata = 32'd0;
      drive(bubble);
      repeat (2) @(negedge clk);
      chk("rst_ctrl", {mem_stall, dmem_req, dmem_we, dmem_be, rd_MEM, reg_write_MEM, mem_read_MEM,
                       wb_valid, wb_rd, wb_reg_write, access_err}, 32'd0);
      chk("rst_addr_wdata", dmem_addr | dmem_wdata, 32'd0);
      chk("rst_alu_mem", alu_result_MEM, 32'd0);
      chk("rst_wb_data", reg_write_data_WB, 32'd0);
      rst_n = 1'b1;

      for (int v = 0; v < 16; v++) run_vec(tbl[v], v);

      // Back-to-back loads acked in their request cycle.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i < 4) drive(mk(32'h100 + 32'(4 * i), 0, 5'(i + 1), 3'b010, 1, 0, 1));
         else drive(bubble);
         dmem_ack   = dmem_req;
         dmem_rdata = dmem_addr ^ 32'h5A5A_0000;
         #1 chk("b2b_no_stall", mem_stall, 1'b0);
         @(posedge clk);
         #1;
         if (i >= 1 && i <= 4) begin
            chk("b2b_wb_valid", {wb_valid, wb_reg_write, wb_rd}, {1'b1, 1'b1, 5'(i)});
            chk("b2b_wb_data", reg_write_data_WB, (32'h100 + 32'(4 * (i - 1))) ^ 32'h5A5A_0000);
         end else if (i == 5) begin
            chk("b2b_drained", wb_valid, 1'b0);
         end
      end

      // Reset in the middle of an access; a late ack must be ignored.
      @(negedge clk);
      dmem_ack = 1'b0;
      drive(mk(32'h200, 0, 2, 3'b010, 1, 0, 1));
      @(negedge clk);
      drive(bubble);
      repeat (2) @(negedge clk);
      chk("rstmid_req_before", dmem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk("rstmid_req_async", {dmem_req, mem_stall}, 2'b00);
      @(negedge clk);
      dmem_ack = 1'b1;
      dmem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1 chk("rstmid_late_ack_ignored", {wb_valid, dmem_req, access_err, mem_stall}, 4'b0000);
      end
      @(negedge clk);
      dmem_ack = 1'b0;

      run_random(400, 60);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
